snap_capture_ctrl: RTL and testbench
====================================

Name: snap_capture_ctrl

Overview:
- Capture controller for the adcsnap0 snapshot buffer, in the user_clk fabric domain.
- Directly downstream of the trig_offset software register: consumes its 32-bit user_data_out as a signed trigger offset.
- Arms on a software strobe and qualifies the trigger against valid ADC samples.
- Drives BRAM write address/data/enable; reports done and the circular start address back to software registers.

Parameters:
- ADDR_W, 10, BRAM address width; DEPTH = 2**ADDR_W samples.
- DATA_W, 64, sample width.
- OFFSET_W, 32, trig_offset width (two's complement).

Ports:
- user_clk  in  1  fabric clock; all logic on rising edge.
- user_rst  in  1  synchronous, active-high reset.
- arm  in  1  software arm; rising edge starts a capture.
- trig_offset  in  OFFSET_W  signed offset from the trig_offset register; sampled only on the arm edge.
- we_in  in  1  sample valid.
- trig  in  1  trigger; honoured only when we_in=1.
- din  in  DATA_W  sample data.
- bram_addr  out  ADDR_W  write address.
- bram_data  out  DATA_W  write data.
- bram_we  out  1  write enable.
- armed  out  1  high in PRE, WAIT_TRIG, DELAY and CAPTURE.
- done  out  1  capture complete; held until the next arm edge or reset.
- start_addr  out  ADDR_W  address of the oldest captured sample.

Behaviour:
- Reset (user_rst=1 at an edge, any state) -> IDLE. bram_addr, bram_data, bram_we, armed, done, start_addr all 0. Arm edge detector cleared, so arm held high through reset does not trigger on release.
- Arm edge = arm && !arm_d. Accepted only in IDLE or DONE; ignored in all other states.
- On an arm edge: latch off = trig_offset, clear done, zero the address and counters.
  - off >= 0 -> WAIT_TRIG.
  - off < 0 -> PRE, with mag = min(-off, DEPTH-1).
  - Most-negative input is clamped; no overflow.
- Latency: every write is registered. Valid sample at edge n appears on bram_we/addr/data at edge n+1.
- Address is 0 on the first write and increments by one per write, wrapping modulo DEPTH.
- Each state handles a valid sample (we_in=1) as follows:
  - WAIT_TRIG: no writes.
    - On trig with off=0 -> CAPTURE; the trig sample itself is written at address 0.
    - On trig with off>0 -> DELAY; cnt = off-1.
  - DELAY: no writes. Decrement cnt; at cnt=0 the current sample is the first written, at address 0, -> CAPTURE. Sample number off after the trigger is the first stored.
  - PRE: write every sample circularly and count fill, saturating at DEPTH.
    - trig with fill < mag (fill counted before this sample) is ignored.
    - Otherwise the trig sample is written at address A; start_addr = (A - mag) mod DEPTH; remaining = DEPTH-mag-1 -> CAPTURE.
  - CAPTURE: write each sample.
    - Positive/zero path ends after exactly DEPTH writes total.
    - Negative path ends after the remaining count.
    - Then -> DONE; done=1 and armed=0 on the edge following the last write.
    - Further trig is ignored.
- start_addr = 0 for off >= 0.
- we_in=0: no write, counters and state hold; trig is ignored on that cycle.
- Simultaneous arm edge and trig: trig ignored, since the block is not yet armed.
- Arm held high: only one capture.

Decomposition:
- Package snap_pkg: state enum (IDLE, PRE, WAIT_TRIG, DELAY, CAPTURE, DONE), DEPTH, and the mag clamp function.
- Optional sub-module snap_addr_gen: wrapping address counter with fill saturation, inc/clear inputs.
- Everything else lives in one FSM.

Test Plan:
- off=0, ADDR_W=10, arm, we_in continuous, trig on sample 5 -> 1024 writes at addr 0..1023; addr 0 = sample 5; done=1 one cycle after the last write; start_addr=0.
- off=+3, trig on sample 5 -> first write at addr 0 = sample 8; no bram_we during DELAY; 1024 writes; done.
- off=-4, trig on sample 9 (samples 0..9 written at addr 0..9) -> start_addr=5; capture ends after 1019 further writes (last write at addr 4); done=1.
- off=-4, trig on sample 2 (fill=2) ignored, trig on sample 6 accepted -> start_addr=2; trig pulsed with we_in=0 never accepted; we_in gaps hold the address.
- trig_offset=-5000 and 0x80000000 -> mag=1023; start_addr = trig addr-1023 mod 1024; capture totals 1024 stored samples; no wrap errors.
- user_rst asserted mid-CAPTURE with arm high -> next edge: all outputs 0, IDLE; no capture until arm is low then high again; re-arm in DONE restarts with a fresh offset.

Source files
------------

// File: rtl/snap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snap_pkg
//  Description : Shared types, sizing constants and the pre-trigger depth
//                clamp for the adcsnap0 capture controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package snap_pkg;

    localparam int c_ADDR_W_DFLT = 10;
    localparam int c_DEPTH_DFLT  = 2 ** c_ADDR_W_DFLT;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_DELAY     = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // Negative offsets become a pre-trigger depth of min(-off, max_mag).
    // Operating on a 64-bit sign-extended value keeps -off exact even for the
    // most negative offset.
    function automatic logic [63:0] mag_clamp(input logic signed [63:0] off,
                                              input logic        [63:0] max_mag);
        logic [63:0] neg;
        neg = 64'(-off);
        if (!off[63]) begin
            return 64'd0;
        end
        return (neg > max_mag) ? max_mag : neg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snap_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : snap_capture_ctrl_if
//  Description : Software, sample-stream and BRAM write signals of the
//                snapshot capture controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface snap_capture_ctrl_if
    import snap_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W_DFLT,
    parameter int DATA_W   = 64,
    parameter int OFFSET_W = 32
);
    logic                arm;
    logic [OFFSET_W-1:0] trig_offset;
    logic                we_in;
    logic                trig;
    logic [DATA_W-1:0]   din;
    logic [ADDR_W-1:0]   bram_addr;
    logic [DATA_W-1:0]   bram_data;
    logic                bram_we;
    logic                armed;
    logic                done;
    logic [ADDR_W-1:0]   start_addr;

    modport master (
        output arm, trig_offset, we_in, trig, din,
        input  bram_addr, bram_data, bram_we, armed, done, start_addr
    );

    modport slave (
        input  arm, trig_offset, we_in, trig, din,
        output bram_addr, bram_data, bram_we, armed, done, start_addr
    );
endinterface
`default_nettype wire

// File: rtl/snap_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : snap_addr_gen
//  Description : Wrapping BRAM write-address counter with a fill count that
//                saturates at the buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module snap_addr_gen
    import snap_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W:0]   o_fill
);

    localparam logic [ADDR_W:0] c_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   fill_q, fill_d;

    always_comb begin
        addr_d = addr_q;
        fill_d = fill_q;
        if (i_clr) begin
            addr_d = '0;
            fill_d = '0;
        end else if (i_inc) begin
            addr_d = addr_q + 1'b1;
            if (fill_q != c_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            fill_q <= '0;
        end else begin
            addr_q <= addr_d;
            fill_q <= fill_d;
        end
    end

    assign o_addr = addr_q;
    assign o_fill = fill_q;

endmodule
`default_nettype wire

// File: rtl/snap_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snap_capture_ctrl
//  Description : adcsnap0 capture FSM - arms on a software strobe, qualifies
//                the trigger with a signed offset and fills the snapshot BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module snap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W_DFLT,
    parameter int DATA_W   = 64,
    parameter int OFFSET_W = 32
) (
    input  logic               user_clk,
    input  logic               user_rst,
    snap_capture_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_LAST = '1;

    state_e              state_q, state_d;
    logic                arm_prev_q, arm_prev_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [OFFSET_W-1:0] dly_q, dly_d;
    logic [ADDR_W-1:0]   mag_q, mag_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic                armed_q, armed_d;
    logic                done_q, done_d;
    logic                bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_data_q, bram_data_d;

    logic                w_arm_ok;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W:0]     w_fill;

    assign w_arm_ok = bus.arm && !arm_prev_q && (state_q == ST_IDLE || state_q == ST_DONE);

    snap_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (user_clk),
        .rst    (user_rst),
        .i_clr  (w_arm_ok),
        .i_inc  (w_wr),
        .o_addr (w_addr),
        .o_fill (w_fill)
    );

    always_comb begin
        state_d     = state_q;
        arm_prev_d  = bus.arm;
        off_d       = off_q;
        dly_d       = dly_q;
        mag_d       = mag_q;
        rem_d       = rem_q;
        start_d     = start_q;
        // armed/done follow the state one edge late so both flip together
        // on the edge after the final BRAM write.
        armed_d     = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) ||
                      (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
        done_d      = done_q || (state_q == ST_DONE);
        w_wr        = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;

        if (w_arm_ok) begin
            off_d   = bus.trig_offset;
            mag_d   = ADDR_W'(mag_clamp(64'(signed'(bus.trig_offset)), 64'(c_LAST)));
            dly_d   = '0;
            rem_d   = '0;
            start_d = '0;
            armed_d = 1'b1;
            done_d  = 1'b0;
            state_d = bus.trig_offset[OFFSET_W-1] ? ST_PRE : ST_WAIT_TRIG;
        end else if (bus.we_in) begin
            case (state_q)
                ST_WAIT_TRIG: begin
                    if (bus.trig) begin
                        if (off_q == '0) begin
                            w_wr    = 1'b1;
                            rem_d   = c_LAST;
                            state_d = ST_CAPTURE;
                        end else begin
                            dly_d   = off_q - 1'b1;
                            state_d = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_q == '0) begin
                        w_wr    = 1'b1;
                        rem_d   = c_LAST;
                        state_d = ST_CAPTURE;
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end
                ST_PRE: begin
                    w_wr = 1'b1;
                    // w_fill counts writes before this sample
                    if (bus.trig && (w_fill >= {1'b0, mag_q})) begin
                        start_d = w_addr - mag_q;
                        rem_d   = c_LAST - mag_q;
                        state_d = (mag_q == c_LAST) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    w_wr  = 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end

        if (w_wr) begin
            bram_we_d   = 1'b1;
            bram_addr_d = w_addr;
            bram_data_d = bus.din;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q     <= ST_IDLE;
            // Treat arm as already high so a level held through reset is not an edge.
            arm_prev_q  <= 1'b1;
            off_q       <= '0;
            dly_q       <= '0;
            mag_q       <= '0;
            rem_q       <= '0;
            start_q     <= '0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
        end else begin
            state_q     <= state_d;
            arm_prev_q  <= arm_prev_d;
            off_q       <= off_d;
            dly_q       <= dly_d;
            mag_q       <= mag_d;
            rem_q       <= rem_d;
            start_q     <= start_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
        end
    end

    assign bus.bram_we    = bram_we_q;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_data  = bram_data_q;
    assign bus.armed      = armed_q;
    assign bus.done       = done_q;
    assign bus.start_addr = start_q;

endmodule
`default_nettype wire

// File: tb/tb_snap_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snap_capture_ctrl
//  Description : Directed self-checking bench for snap_capture_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snap_capture_ctrl;
    import snap_pkg::*;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 64;
    localparam int OFFSET_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [63:0] mem [0:c_DEPTH_DFLT-1];
    int   wr_cnt        = 0;
    int   last_addr     = 0;
    int   last_we_cyc   = 0;
    int   done_rise_cyc = 0;
    logic done_prev     = 1'b0;

    snap_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) bus ();

    snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) dut (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every BRAM write into a shadow memory away from the active edge.
    always @(negedge clk) begin
        if (bus.bram_we === 1'b1) begin
            mem[bus.bram_addr] = bus.bram_data;
            wr_cnt++;
            last_addr   = int'(bus.bram_addr);
            last_we_cyc = cyc;
        end
        if (bus.done === 1'b1 && !done_prev) done_rise_cyc = cyc;
        done_prev = (bus.done === 1'b1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input int tid, input int s);
        return {8'(tid), 24'h0, 32'(s)};
    endfunction

    task automatic do_arm(input logic [31:0] off, input bit with_trig);
        bus.arm = 1'b0; bus.we_in = 1'b0; bus.trig = 1'b0;
        tick();
        bus.trig_offset = off;
        bus.arm   = 1'b1;
        bus.we_in = with_trig;
        bus.trig  = with_trig;
        bus.din   = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.we_in = 1'b0; bus.trig = 1'b0;
    endtask

    // Feed valid samples numbered from 0; optional idle cycles carry trig=1.
    task automatic run_capture(input int tid, input int t1, input int t2,
                               input bit gaps, input int budget);
        int s = 0;
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            bus.we_in = 1'b1;
            bus.trig  = (s == t1) || (s == t2);
            bus.din   = mk(tid, s);
            tick();
            s++; n++;
            if (gaps && (s % 3 == 1) && bus.done !== 1'b1) begin
                bus.we_in = 1'b0; bus.trig = 1'b1; bus.din = '1;
                tick();
                n++;
            end
        end
        bus.we_in = 1'b0; bus.trig = 1'b0;
        tick();
        check($sformatf("t%0d_reach_done", tid), 64'(bus.done), 64'd1);
    endtask

    task automatic expect_run(input int tid, input int base, input int exp_wr,
                              input int exp_start, input int exp_last,
                              input int a0, input logic [63:0] d0,
                              input int a1, input logic [63:0] d1);
        check($sformatf("t%0d_writes", tid), 64'(wr_cnt - base), 64'(exp_wr));
        check($sformatf("t%0d_start_addr", tid), 64'(bus.start_addr), 64'(exp_start));
        check($sformatf("t%0d_last_addr", tid), 64'(last_addr), 64'(exp_last));
        check($sformatf("t%0d_mem[%0d]", tid, a0), mem[a0], d0);
        check($sformatf("t%0d_mem[%0d]", tid, a1), mem[a1], d1);
        check($sformatf("t%0d_armed_low", tid), 64'(bus.armed), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bram_we"},    64'(bus.bram_we),    64'd0);
        check({tag, "_bram_addr"},  64'(bus.bram_addr),  64'd0);
        check({tag, "_bram_data"},  64'(bus.bram_data),  64'd0);
        check({tag, "_armed"},      64'(bus.armed),      64'd0);
        check({tag, "_done"},       64'(bus.done),       64'd0);
        check({tag, "_start_addr"}, 64'(bus.start_addr), 64'd0);
    endtask

    initial begin
        int base;
        bus.arm = 1'b0; bus.trig_offset = '0; bus.we_in = 1'b0;
        bus.trig = 1'b0; bus.din = '0;

        rst = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // off=0; trig on the arm cycle itself must be ignored
        base = wr_cnt;
        do_arm(32'd0, 1'b1);
        check("t1_armed", 64'(bus.armed), 64'd1);
        run_capture(1, 5, -1, 1'b0, 3000);
        expect_run(1, base, 1024, 0, 1023, 0, mk(1, 5), 1023, mk(1, 1028));
        check("t1_done_latency", 64'(done_rise_cyc - last_we_cyc), 64'd1);

        // off=+3, re-armed from DONE
        base = wr_cnt;
        do_arm(32'd3, 1'b0);
        run_capture(2, 5, -1, 1'b0, 3000);
        expect_run(2, base, 1024, 0, 1023, 0, mk(2, 8), 1023, mk(2, 1031));

        // off=-4, trig on sample 9
        base = wr_cnt;
        do_arm(-32'sd4, 1'b0);
        run_capture(3, 9, -1, 1'b0, 3000);
        expect_run(3, base, 1029, 5, 4, 4, mk(3, 1028), 5, mk(3, 5));
        check("t3_done_latency", 64'(done_rise_cyc - last_we_cyc), 64'd1);

        // off=-4, early trig ignored, idle cycles carry trig and hold address
        base = wr_cnt;
        do_arm(-32'sd4, 1'b0);
        run_capture(4, 2, 6, 1'b1, 4000);
        expect_run(4, base, 1026, 2, 1, 1, mk(4, 1025), 2, mk(4, 2));
        check("t4_mem[7]", mem[7], mk(4, 7));

        // off=-5000 clamps to 1023
        base = wr_cnt;
        do_arm(-32'sd5000, 1'b0);
        run_capture(5, 500, 1100, 1'b0, 3000);
        expect_run(5, base, 1101, 77, 76, 76, mk(5, 1100), 77, mk(5, 77));

        // most negative offset, fill boundary at 1022/1023
        base = wr_cnt;
        do_arm(32'h8000_0000, 1'b0);
        run_capture(6, 1022, 1023, 1'b0, 3000);
        expect_run(6, base, 1024, 0, 1023, 0, mk(6, 0), 1023, mk(6, 1023));

        // reset mid-CAPTURE with arm held high
        do_arm(32'd0, 1'b0);
        for (int i = 0; i < 21; i++) begin
            bus.we_in = 1'b1; bus.trig = (i == 0); bus.din = mk(8, i);
            tick();
        end
        check("t6_armed_mid", 64'(bus.armed), 64'd1);
        rst = 1'b1;
        tick();
        check_idle_outputs("t6_rst");
        rst = 1'b0;
        base = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.we_in = 1'b1; bus.trig = 1'b1; bus.din = mk(9, i);
            tick();
        end
        bus.we_in = 1'b0; bus.trig = 1'b0;
        tick();
        check("t6_no_rearm_armed", 64'(bus.armed), 64'd0);
        check("t6_no_rearm_writes", 64'(wr_cnt - base), 64'd0);

        base = wr_cnt;
        do_arm(32'hFFFF_FFFF, 1'b0);
        run_capture(7, 3, -1, 1'b0, 3000);
        expect_run(7, base, 1026, 2, 1, 1, mk(7, 1025), 2, mk(7, 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
